vram_fill_dma: RTL and testbench

Block-fill DMA engine for the character display memories: character RAM, foreground colour RAM and background colour RAM. The CPU configures the block through a memory-mapped register page. On start, the block writes constant values into a contiguous address range of any combination of the three planes. It shares each RAM's CPU-side port with the CPU and gives the CPU absolute priority, so it only writes on cycles the CPU leaves the video RAMs idle.

---
 rtl/vram_fill_dma.sv | 175 +++++++++++++++++
 tb/tb_vram_fill_dma.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_fill_dma.sv
// Block-fill DMA for the character, foreground-colour and background-colour RAMs.
// Writes constant values over an address range, only on cycles the CPU leaves the video RAMs idle.
module vram_fill_dma #(
   parameter int ADDR_W = 11,
   parameter int LEN_W  = 12
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic [15:0]       cpu_addr,
   input  logic [7:0]        cpu_dout,
   input  logic              cpu_wr_n,
   input  logic              regs_cs,
   output logic [7:0]        regs_dout,
   input  logic              vram_cpu_cs,
   output logic [ADDR_W-1:0] dma_addr,
   output logic [7:0]        dma_char,
   output logic [7:0]        dma_fg,
   output logic [7:0]        dma_bg,
   output logic              dma_wr_chram,
   output logic              dma_wr_fg,
   output logic              dma_wr_bg,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0] addr_reg_q, addr_reg_d;
   logic [LEN_W-1:0]  len_reg_q, len_reg_d;
   logic [7:0]        char_q, char_d;
   logic [7:0]        fg_q, fg_d;
   logic [7:0]        bg_q, bg_d;
   logic [2:0]        plane_en_q, plane_en_d;
   logic              wr_prev_q, wr_prev_d;
   logic [ADDR_W-1:0] dma_addr_q, dma_addr_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;

   logic [2:0] reg_sel;
   logic       wr_level;
   logic       wr_pulse;
   logic       ctrl_wr;
   logic       start_req;
   logic       abort_req;
   logic       filling;
   logic       fill_wr;
   logic       unused_addr_bits;

   assign unused_addr_bits = ^cpu_addr[15:3];

   // A write acts only on the cycle the qualified strobe rises.
   assign reg_sel   = cpu_addr[2:0];
   assign wr_level  = regs_cs & ~cpu_wr_n;
   assign wr_pulse  = wr_level & ~wr_prev_q;
   assign wr_prev_d = wr_level;

   assign ctrl_wr   = wr_pulse & (reg_sel == 3'd7);
   assign abort_req = ctrl_wr & cpu_dout[7];
   assign start_req = ctrl_wr & cpu_dout[0] & ~cpu_dout[7];

   assign filling = (state_q == S_FILL);
   assign fill_wr = filling & ~vram_cpu_cs;

   // Configuration registers; frozen while a fill is running.
   always_comb begin
      addr_reg_d = addr_reg_q;
      len_reg_d  = len_reg_q;
      char_d     = char_q;
      fg_d       = fg_q;
      bg_d       = bg_q;
      plane_en_d = plane_en_q;
      if (wr_pulse && !filling) begin
         case (reg_sel)
            3'd0: addr_reg_d[7:0]        = cpu_dout;
            3'd1: addr_reg_d[ADDR_W-1:8] = cpu_dout[ADDR_W-9:0];
            3'd2: len_reg_d[7:0]         = cpu_dout;
            3'd3: len_reg_d[LEN_W-1:8]   = cpu_dout[LEN_W-9:0];
            3'd4: char_d                 = cpu_dout;
            3'd5: fg_d                   = cpu_dout;
            3'd6: bg_d                   = cpu_dout;
            default: plane_en_d          = cpu_dout[3:1];
         endcase
      end
   end

   // Sequencer: a start in IDLE or DONE uses the enables carried by the start write itself.
   always_comb begin
      state_d    = state_q;
      dma_addr_d = dma_addr_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start_req) begin
               if ((len_reg_q != '0) && (cpu_dout[3:1] != 3'b000)) begin
                  state_d    = S_FILL;
                  dma_addr_d = addr_reg_q;
                  cnt_d      = len_reg_q;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_FILL: begin
            if (!vram_cpu_cs) begin
               dma_addr_d = dma_addr_q + ADDR_W'(1);
               cnt_d      = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) begin
                  state_d = S_DONE;
               end
            end
            if (abort_req) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= S_IDLE;
         addr_reg_q <= '0;
         len_reg_q  <= '0;
         char_q     <= '0;
         fg_q       <= '0;
         bg_q       <= '0;
         plane_en_q <= '0;
         wr_prev_q  <= 1'b0;
         dma_addr_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_reg_q <= addr_reg_d;
         len_reg_q  <= len_reg_d;
         char_q     <= char_d;
         fg_q       <= fg_d;
         bg_q       <= bg_d;
         plane_en_q <= plane_en_d;
         wr_prev_q  <= wr_prev_d;
         dma_addr_q <= dma_addr_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      regs_dout = 8'h00;
      case (reg_sel)
         3'd0:    regs_dout = addr_reg_q[7:0];
         3'd1:    regs_dout = 8'(addr_reg_q[ADDR_W-1:8]);
         3'd2:    regs_dout = len_reg_q[7:0];
         3'd3:    regs_dout = 8'(len_reg_q[LEN_W-1:8]);
         3'd4:    regs_dout = char_q;
         3'd5:    regs_dout = fg_q;
         3'd6:    regs_dout = bg_q;
         default: regs_dout = {filling, 4'b0000, plane_en_q};
      endcase
   end

   assign dma_addr     = dma_addr_q;
   assign dma_char     = char_q;
   assign dma_fg       = fg_q;
   assign dma_bg       = bg_q;
   assign dma_wr_chram = fill_wr & plane_en_q[0];
   assign dma_wr_fg    = fill_wr & plane_en_q[1];
   assign dma_wr_bg    = fill_wr & plane_en_q[2];
   assign busy         = filling;
   assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_vram_fill_dma.sv
// Bench for vram_fill_dma: register vectors, directed fills and randomized fills
// checked against a queue-style model of which cells get written when.
module tb_vram_fill_dma;

   logic        clk_sys;
   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic        cpu_wr_n;
   logic        regs_cs;
   logic [7:0]  regs_dout;
   logic        vram_cpu_cs;
   logic [10:0] dma_addr;
   logic [7:0]  dma_char, dma_fg, dma_bg;
   logic        dma_wr_chram, dma_wr_fg, dma_wr_bg;
   logic        busy, done;

   int checks = 0;
   int failures = 0;

   logic [7:0] tb_ch [2048];
   logic [7:0] tb_fg [2048];
   logic [7:0] tb_bg [2048];
   logic [7:0] exp_ch [2048];
   logic [7:0] exp_fg [2048];
   logic [7:0] exp_bg [2048];

   typedef struct {
      logic [2:0] rsel;
      logic [7:0] wdata;
      logic [7:0] exp_rd;
   } reg_vec_t;

   reg_vec_t vecs [10];

   vram_fill_dma #(.ADDR_W(11), .LEN_W(12)) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .cpu_addr     (cpu_addr),
      .cpu_dout     (cpu_dout),
      .cpu_wr_n     (cpu_wr_n),
      .regs_cs      (regs_cs),
      .regs_dout    (regs_dout),
      .vram_cpu_cs  (vram_cpu_cs),
      .dma_addr     (dma_addr),
      .dma_char     (dma_char),
      .dma_fg       (dma_fg),
      .dma_bg       (dma_bg),
      .dma_wr_chram (dma_wr_chram),
      .dma_wr_fg    (dma_wr_fg),
      .dma_wr_bg    (dma_wr_bg),
      .busy         (busy),
      .done         (done)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // Video RAMs fed by the strobes, as the external port mux would do.
   always @(posedge clk_sys) begin
      if (dma_wr_chram) tb_ch[dma_addr] <= dma_char;
      if (dma_wr_fg)    tb_fg[dma_addr] <= dma_fg;
      if (dma_wr_bg)    tb_bg[dma_addr] <= dma_bg;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic write_reg(input logic [2:0] r, input logic [7:0] v);
      cpu_addr = 16'h7900 | {13'b0, r};
      cpu_dout = v;
      regs_cs  = 1'b1;
      cpu_wr_n = 1'b0;
      tick();
      regs_cs  = 1'b0;
      cpu_wr_n = 1'b1;
      tick();
   endtask

   // Leaves the bench in cycle T+1 of the qualified start write.
   task automatic start_write(input logic [7:0] v);
      cpu_addr = 16'h7907;
      cpu_dout = v;
      regs_cs  = 1'b1;
      cpu_wr_n = 1'b0;
      tick();
      regs_cs  = 1'b0;
      cpu_wr_n = 1'b1;
   endtask

   task automatic read_check(input logic [2:0] r, input logic [7:0] exp, input string name);
      cpu_addr = 16'h7900 | {13'b0, r};
      @(negedge clk_sys);
      check(name, regs_dout, exp);
   endtask

   task automatic model_write(input logic [10:0] a, input logic [2:0] p,
                              input logic [7:0] ch, input logic [7:0] fg, input logic [7:0] bg);
      if (p[0]) exp_ch[a] = ch;
      if (p[1]) exp_fg[a] = fg;
      if (p[2]) exp_bg[a] = bg;
   endtask

   task automatic ram_check(input string name);
      int diffs = 0;
      for (int i = 0; i < 2048; i++) begin
         if (tb_ch[i] !== exp_ch[i]) diffs++;
         if (tb_fg[i] !== exp_fg[i]) diffs++;
         if (tb_bg[i] !== exp_bg[i]) diffs++;
      end
      check(name, diffs, 0);
   endtask

   // Expected behaviour: the n cells a, a+1, ... (mod 2048) are written in order, one per
   // cycle in which the CPU leaves the RAMs alone; done follows the last write by one cycle.
   task automatic run_fill(input logic [10:0] a, input int n, input logic [2:0] p,
                           input logic [7:0] ch, input logic [7:0] fg, input logic [7:0] bg,
                           input int cs_after, input int cs_len, input int cs_pct,
                           output int busy_cycles);
      logic [10:0] na;
      logic [11:0] nl;
      logic [2:0]  exp_wr;
      int rem, written, hold, contended, done_cnt, bound;
      bit done_due, done_next, fin, cs;
      nl = 12'(n);
      write_reg(3'd0, a[7:0]);
      write_reg(3'd1, {5'b0, a[10:8]});
      write_reg(3'd2, nl[7:0]);
      write_reg(3'd3, {4'b0, nl[11:8]});
      write_reg(3'd4, ch);
      write_reg(3'd5, fg);
      write_reg(3'd6, bg);
      start_write({4'b0, p, 1'b1});
      na = a;
      rem = (n != 0 && p != 3'b000) ? n : 0;
      done_due = (rem == 0);
      written = 0;
      hold = cs_len;
      contended = 0;
      busy_cycles = 0;
      done_cnt = 0;
      fin = 0;
      bound = n * 8 + cs_len + 20;
      for (int cyc = 0; cyc < bound && !fin; cyc++) begin
         cs = 0;
         if (rem > 0) begin
            if (written >= cs_after && hold > 0) begin
               cs = 1;
               hold--;
            end else if ($urandom_range(99) < cs_pct) begin
               cs = 1;
            end
         end
         vram_cpu_cs = cs;
         @(negedge clk_sys);
         exp_wr = (rem > 0 && !cs) ? p : 3'b000;
         check("fill_busy", busy, (rem > 0));
         check("fill_done", done, done_due);
         check("fill_strobes", {dma_wr_bg, dma_wr_fg, dma_wr_chram}, exp_wr);
         if (exp_wr != 3'b000) check("fill_addr", dma_addr, na);
         if (busy) busy_cycles++;
         if (done) done_cnt++;
         if (rem > 0 && cs) contended++;
         done_next = 0;
         if (exp_wr != 3'b000) begin
            model_write(na, p, ch, fg, bg);
            na = na + 11'd1;
            rem--;
            written++;
            if (rem == 0) done_next = 1;
         end
         fin = done_due;
         done_due = done_next;
         tick();
      end
      vram_cpu_cs = 1'b0;
      if (!fin) check("fill_timeout", 0, 1);
      check("fill_busy_cycles", busy_cycles, ((n != 0 && p != 3'b000) ? n : 0) + contended);
      check("fill_done_count", done_cnt, 1);
      ram_check("fill_ram");
   endtask

   initial begin
      int bc, strobe_cycles, done_pulses;
      logic [10:0] ra;
      logic [2:0]  rp;
      int          rn;

      vecs[0] = '{3'd0, 8'hA5, 8'hA5};
      vecs[1] = '{3'd1, 8'hFD, 8'h05};
      vecs[2] = '{3'd2, 8'h3C, 8'h3C};
      vecs[3] = '{3'd3, 8'hF9, 8'h09};
      vecs[4] = '{3'd4, 8'h41, 8'h41};
      vecs[5] = '{3'd5, 8'h7E, 8'h7E};
      vecs[6] = '{3'd6, 8'h81, 8'h81};
      vecs[7] = '{3'd7, 8'h0E, 8'h07};
      vecs[8] = '{3'd7, 8'h04, 8'h02};
      vecs[9] = '{3'd1, 8'h03, 8'h03};

      for (int i = 0; i < 2048; i++) begin
         tb_ch[i] = 8'h00; tb_fg[i] = 8'h00; tb_bg[i] = 8'h00;
         exp_ch[i] = 8'h00; exp_fg[i] = 8'h00; exp_bg[i] = 8'h00;
      end

      reset = 1'b1;
      cpu_addr = 16'h0000;
      cpu_dout = 8'h00;
      cpu_wr_n = 1'b1;
      regs_cs = 1'b0;
      vram_cpu_cs = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      @(negedge clk_sys);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_strobes", {dma_wr_bg, dma_wr_fg, dma_wr_chram}, 0);
      check("rst_addr", dma_addr, 0);
      for (int r = 0; r < 8; r++) read_check(3'(r), 8'h00, "rst_reg");
      tick();

      for (int i = 0; i < 10; i++) begin
         write_reg(vecs[i].rsel, vecs[i].wdata);
         read_check(vecs[i].rsel, vecs[i].exp_rd, "reg_vec");
         tick();
      end
      check("vec_dma_char", dma_char, 8'h41);
      check("vec_dma_fg", dma_fg, 8'h7E);
      check("vec_dma_bg", dma_bg, 8'h81);
      check("vec_idle", busy, 0);

      run_fill(11'h000, 40, 3'b111, 8'h20, 8'hFF, 8'h00, 1000, 0, 0, bc);
      check("basic_busy40", bc, 40);
      run_fill(11'h000, 40, 3'b111, 8'h20, 8'hFF, 8'h00, 10, 5, 0, bc);
      check("contend_busy45", bc, 45);
      run_fill(11'h7FE, 4, 3'b001, 8'h5A, 8'h11, 8'h22, 1000, 0, 0, bc);
      check("wrap_busy4", bc, 4);
      run_fill(11'h100, 0, 3'b111, 8'h33, 8'h44, 8'h55, 1000, 0, 0, bc);
      check("degen_len0_busy", bc, 0);
      run_fill(11'h100, 5, 3'b000, 8'h33, 8'h44, 8'h55, 1000, 0, 0, bc);
      check("degen_pl0_busy", bc, 0);

      for (int k = 0; k < 8; k++) begin
         ra = 11'($urandom_range(2047));
         rn = ($urandom_range(9) == 0) ? 0 : $urandom_range(60, 1);
         rp = 3'($urandom_range(7));
         run_fill(ra, rn, rp, 8'($urandom), 8'($urandom), 8'($urandom),
                  1000, 0, 30, bc);
      end

      // Abort after ten writes; the abort cycle itself is held contended.
      write_reg(3'd0, 8'h00);
      write_reg(3'd1, 8'h01);
      write_reg(3'd2, 8'd100);
      write_reg(3'd3, 8'h00);
      write_reg(3'd4, 8'hC1);
      write_reg(3'd5, 8'hC2);
      write_reg(3'd6, 8'hC3);
      start_write(8'h0F);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_sys);
         check("abort_pre_strobes", {dma_wr_bg, dma_wr_fg, dma_wr_chram}, 3'b111);
         check("abort_pre_addr", dma_addr, 11'h100 + 11'(i));
         model_write(11'h100 + 11'(i), 3'b111, 8'hC1, 8'hC2, 8'hC3);
         tick();
      end
      vram_cpu_cs = 1'b1;
      cpu_addr = 16'h7907;
      cpu_dout = 8'h80;
      regs_cs = 1'b1;
      cpu_wr_n = 1'b0;
      tick();
      regs_cs = 1'b0;
      cpu_wr_n = 1'b1;
      vram_cpu_cs = 1'b0;
      strobe_cycles = 0;
      done_pulses = 0;
      @(negedge clk_sys);
      check("abort_busy_next", busy, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_sys);
         if (dma_wr_bg | dma_wr_fg | dma_wr_chram) strobe_cycles++;
         if (done) done_pulses++;
         tick();
      end
      check("abort_no_strobes", strobe_cycles, 0);
      check("abort_no_done", done_pulses, 0);
      ram_check("abort_ram");

      // Reset mid-fill; the reset cycle is held contended.
      write_reg(3'd0, 8'h00);
      write_reg(3'd1, 8'h02);
      start_write(8'h0F);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_sys);
         check("rstfill_strobes", {dma_wr_bg, dma_wr_fg, dma_wr_chram}, 3'b111);
         model_write(11'h200 + 11'(i), 3'b111, 8'hC1, 8'hC2, 8'hC3);
         tick();
      end
      vram_cpu_cs = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vram_cpu_cs = 1'b0;
      @(negedge clk_sys);
      check("rstfill_busy", busy, 0);
      check("rstfill_done", done, 0);
      check("rstfill_addr", dma_addr, 0);
      for (int r = 0; r < 8; r++) read_check(3'(r), 8'h00, "rstfill_reg");
      done_pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         @(negedge clk_sys);
         if (done | busy) done_pulses++;
      end
      check("rstfill_quiet", done_pulses, 0);
      tick();
      ram_check("rstfill_ram");

      // Control write held for six cycles must start exactly one fill.
      write_reg(3'd0, 8'h00);
      write_reg(3'd1, 8'h03);
      write_reg(3'd2, 8'd3);
      write_reg(3'd4, 8'h55);
      write_reg(3'd5, 8'h66);
      write_reg(3'd6, 8'h77);
      cpu_addr = 16'h7907;
      cpu_dout = 8'h0F;
      regs_cs = 1'b1;
      cpu_wr_n = 1'b0;
      strobe_cycles = 0;
      done_pulses = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_sys);
         if (dma_wr_bg | dma_wr_fg | dma_wr_chram) begin
            model_write(11'h300 + 11'(strobe_cycles), 3'b111, 8'h55, 8'h66, 8'h77);
            strobe_cycles++;
         end
         if (done) done_pulses++;
         tick();
         if (i == 5) begin
            regs_cs = 1'b0;
            cpu_wr_n = 1'b1;
         end
      end
      check("held_strobe_cycles", strobe_cycles, 3);
      check("held_done_pulses", done_pulses, 1);
      ram_check("held_ram");

      // Config writes while busy are dropped; control reads show busy.
      write_reg(3'd0, 8'h00);
      write_reg(3'd1, 8'h04);
      write_reg(3'd2, 8'd20);
      write_reg(3'd4, 8'h20);
      write_reg(3'd5, 8'h21);
      write_reg(3'd6, 8'h22);
      start_write(8'h0F);
      vram_cpu_cs = 1'b1;
      write_reg(3'd4, 8'h41);
      read_check(3'd4, 8'h20, "busy_reg4_kept");
      read_check(3'd7, 8'h87, "busy_reg7");
      check("busy_dma_char", dma_char, 8'h20);
      tick();
      vram_cpu_cs = 1'b0;
      strobe_cycles = 0;
      done_pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_sys);
         if ({dma_wr_bg, dma_wr_fg, dma_wr_chram} == 3'b111) begin
            model_write(11'h400 + 11'(strobe_cycles), 3'b111, 8'h20, 8'h21, 8'h22);
            strobe_cycles++;
         end
         if (done) done_pulses++;
         tick();
      end
      check("busy_strobe_cycles", strobe_cycles, 20);
      check("busy_done_pulses", done_pulses, 1);
      read_check(3'd7, 8'h07, "after_reg7");
      read_check(3'd4, 8'h20, "after_reg4");
      tick();
      ram_check("final_ram");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
